// File: rtl/crc16_pkg.sv
// Shared CRC-16 (poly 0x1021, MSB-first) constants, checker FSM states and result codes.
// Also used by crc16_parallel; the fold function is the single source of the CRC math.
package crc16_pkg;

  localparam logic [15:0] CRC16_POLY = 16'h1021;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_CRC   = 2'b01;
  localparam logic [1:0] ERR_LEN   = 2'b10;
  localparam logic [1:0] ERR_ABORT = 2'b11;

  // ((crc ^ word) * x^16) mod G, one bit per iteration, MSB first.
  function automatic logic [15:0] crc16_fold(input logic [15:0] crc, input logic [15:0] word);
    logic [15:0] c;
    c = crc ^ word;
    for (int i = 0; i < 16; i++) begin
      c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc16_step.sv
// Combinational one-word CRC-16 fold: crc_out = step(crc_in, data_in).
// Latency: 0 cycles. Backpressure: none (pure logic).
module crc16_step
  import crc16_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [15:0] data_in,
  output logic [15:0] crc_out
);

  assign crc_out = crc16_fold(crc_in, data_in);

endmodule

// File: rtl/crc16_frame_checker.sv
// CRC-16 frame checker: folds data words, compares the trailing CRC word, reports a registered result.
// Latency: result pulse 1 cycle after the eof/abort transfer. Backpressure: in_ready low for the one REPORT cycle and in reset.
// Optional good/bad frame counters enabled by defining CRC16_CHK_STATS_EN.
module crc16_frame_checker
  import crc16_pkg::*;
#(
  parameter logic [15:0] CRC_INIT  = 16'hFFFF,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_sof,
  input  logic        in_eof,
  output logic        chk_valid,
  output logic        chk_ok,
  output logic [1:0]  chk_err,
  output logic [15:0] crc_calc,
`ifdef CRC16_CHK_STATS_EN
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt,
`endif
  output logic [15:0] frame_len
);

  state_t      r_state;
  logic [15:0] r_crc;
  logic [15:0] r_count;
  logic        r_chk_valid;
  logic        r_chk_ok;
  logic [1:0]  r_chk_err;
  logic [15:0] r_crc_calc;
  logic [15:0] r_frame_len;

  logic        w_fire;
  logic        w_too_long;
  logic [15:0] w_step_crc_in;
  logic [15:0] w_step_out;

  assign in_ready   = reset_n && (r_state != ST_REPORT);
  assign w_fire     = in_valid && in_ready;
  assign w_too_long = (32'(r_count) > 32'(MAX_WORDS));

  // A sof word always starts from CRC_INIT, even when it aborts a frame in progress.
  assign w_step_crc_in = (r_state == ST_DATA && !in_sof) ? r_crc : CRC_INIT;

  crc16_step u_step (
    .crc_in  (w_step_crc_in),
    .data_in (in_data),
    .crc_out (w_step_out)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_crc       <= CRC_INIT;
      r_count     <= 16'd0;
      r_chk_valid <= 1'b0;
      r_chk_ok    <= 1'b0;
      r_chk_err   <= ERR_NONE;
      r_crc_calc  <= CRC_INIT;
      r_frame_len <= 16'd0;
    end else begin
      r_chk_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_fire && in_sof) begin
            if (in_eof) begin
              r_chk_valid <= 1'b1;
              r_chk_ok    <= 1'b0;
              r_chk_err   <= ERR_LEN;
              r_crc_calc  <= CRC_INIT;
              r_frame_len <= 16'd0;
              r_state     <= ST_REPORT;
            end else begin
              r_crc   <= w_step_out;
              r_count <= 16'd1;
              r_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_fire) begin
            if (in_sof) begin
              r_chk_valid <= 1'b1;
              r_chk_ok    <= 1'b0;
              r_chk_err   <= ERR_ABORT;
              r_crc_calc  <= r_crc;
              r_frame_len <= r_count;
              if (in_eof) begin
                r_state <= ST_REPORT;
              end else begin
                r_crc   <= w_step_out;
                r_count <= 16'd1;
              end
            end else if (in_eof) begin
              r_chk_valid <= 1'b1;
              r_chk_ok    <= !w_too_long && (in_data == r_crc);
              r_chk_err   <= w_too_long ? ERR_LEN : ((in_data == r_crc) ? ERR_NONE : ERR_CRC);
              r_crc_calc  <= r_crc;
              r_frame_len <= r_count;
              r_state     <= ST_REPORT;
            end else begin
              r_crc   <= w_step_out;
              r_count <= (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;
            end
          end
        end
        ST_REPORT: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign chk_valid = r_chk_valid;
  assign chk_ok    = r_chk_ok;
  assign chk_err   = r_chk_err;
  assign crc_calc  = r_crc_calc;
  assign frame_len = r_frame_len;

`ifdef CRC16_CHK_STATS_EN
  logic [15:0] r_good_cnt;
  logic [15:0] r_bad_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_good_cnt <= 16'd0;
      r_bad_cnt  <= 16'd0;
    end else if (r_chk_valid) begin
      if (r_chk_ok && r_good_cnt != 16'hFFFF) r_good_cnt <= r_good_cnt + 16'd1;
      if (!r_chk_ok && r_bad_cnt != 16'hFFFF) r_bad_cnt <= r_bad_cnt + 16'd1;
    end
  end

  assign good_cnt = r_good_cnt;
  assign bad_cnt  = r_bad_cnt;
`endif

endmodule

// File: tb/tb_crc16_frame_checker.sv
// Directed bench: three checker instances (INIT=0; default; INIT=0 with MAX_WORDS=2) share one input stream.
// Expected values are hand-derived from the CRC-16/0x1021 word-fold definition.
module tb_crc16_frame_checker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_sof;
  logic        in_eof;

  logic [2:0]  rdy;
  logic [2:0]  v;
  logic [2:0]  ok;
  logic [1:0]  err [3];
  logic [15:0] crc [3];
  logic [15:0] len [3];
`ifdef CRC16_CHK_STATS_EN
  logic [15:0] good [3];
  logic [15:0] bad  [3];
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  crc16_frame_checker #(.CRC_INIT(16'h0000), .MAX_WORDS(256)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_data(in_data), .in_sof(in_sof), .in_eof(in_eof),
    .chk_valid(v[0]), .chk_ok(ok[0]), .chk_err(err[0]), .crc_calc(crc[0]),
`ifdef CRC16_CHK_STATS_EN
    .good_cnt(good[0]), .bad_cnt(bad[0]),
`endif
    .frame_len(len[0]));

  crc16_frame_checker dut_b (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_data(in_data), .in_sof(in_sof), .in_eof(in_eof),
    .chk_valid(v[1]), .chk_ok(ok[1]), .chk_err(err[1]), .crc_calc(crc[1]),
`ifdef CRC16_CHK_STATS_EN
    .good_cnt(good[1]), .bad_cnt(bad[1]),
`endif
    .frame_len(len[1]));

  crc16_frame_checker #(.CRC_INIT(16'h0000), .MAX_WORDS(2)) dut_c (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_data(in_data), .in_sof(in_sof), .in_eof(in_eof),
    .chk_valid(v[2]), .chk_ok(ok[2]), .chk_err(err[2]), .crc_calc(crc[2]),
`ifdef CRC16_CHK_STATS_EN
    .good_cnt(good[2]), .bad_cnt(bad[2]),
`endif
    .frame_len(len[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word, wait (bounded) for in_ready, transfer it; returns #1 after the transfer edge.
  task automatic xfer(input logic sof, input logic eof, input logic [15:0] d);
    int n;
    n = 0;
    in_valid = 1'b1; in_sof = sof; in_eof = eof; in_data = d;
    while (rdy[1] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (rdy[1] !== 1'b1) begin
      errors++;
      $display("FAIL xfer_ready_timeout: in_ready=%b required 1", rdy[1]);
    end
    tick();
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    checks++; if (rdy !== 3'b000) begin errors++; $display("FAIL reset_in_ready: got %b required 000", rdy); end
    checks++; if (v !== 3'b000) begin errors++; $display("FAIL reset_chk_valid: got %b required 000", v); end
    checks++; if (ok !== 3'b000) begin errors++; $display("FAIL reset_chk_ok: got %b required 000", ok); end
    checks++; if (err[1] !== 2'b00) begin errors++; $display("FAIL reset_chk_err: got %b required 00", err[1]); end
    checks++; if (len[1] !== 16'd0) begin errors++; $display("FAIL reset_frame_len: got %h required 0000", len[1]); end
    checks++; if (crc[1] !== 16'hFFFF) begin errors++; $display("FAIL reset_crc_calc_b: got %h required ffff", crc[1]); end
    checks++; if (crc[0] !== 16'h0000) begin errors++; $display("FAIL reset_crc_calc_a: got %h required 0000", crc[0]); end
    reset_n = 1'b1;
    tick();
    checks++; if (rdy !== 3'b111) begin errors++; $display("FAIL idle_in_ready: got %b required 111", rdy); end
  endtask

  task automatic test_idle_ignore();
    xfer(1'b0, 1'b0, 16'hABCD);
    xfer(1'b0, 1'b1, 16'h1234);
    tick();
    checks++; if (v !== 3'b000) begin errors++; $display("FAIL idle_no_report: got %b required 000", v); end
    checks++; if (rdy !== 3'b111) begin errors++; $display("FAIL idle_ready_kept: got %b required 111", rdy); end
  endtask

  task automatic test_match();
    xfer(1'b1, 1'b0, 16'h0001);
    checks++; if (v[0] !== 1'b0) begin errors++; $display("FAIL match_no_early_valid: got %b required 0", v[0]); end
    xfer(1'b0, 1'b1, 16'h1021);
    checks++; if (v[0] !== 1'b1) begin errors++; $display("FAIL match_valid: got %b required 1", v[0]); end
    checks++; if (ok[0] !== 1'b1) begin errors++; $display("FAIL match_ok: got %b required 1", ok[0]); end
    checks++; if (err[0] !== 2'b00) begin errors++; $display("FAIL match_err: got %b required 00", err[0]); end
    checks++; if (crc[0] !== 16'h1021) begin errors++; $display("FAIL match_crc: got %h required 1021", crc[0]); end
    checks++; if (len[0] !== 16'd1) begin errors++; $display("FAIL match_len: got %0d required 1", len[0]); end
    tick();
    checks++; if (v[0] !== 1'b0) begin errors++; $display("FAIL match_pulse_width: got %b required 0", v[0]); end
  endtask

  task automatic test_mismatch();
    xfer(1'b1, 1'b0, 16'h0002);
    xfer(1'b0, 1'b1, 16'h1021);
    checks++; if (v[0] !== 1'b1) begin errors++; $display("FAIL mismatch_valid: got %b required 1", v[0]); end
    checks++; if (ok[0] !== 1'b0) begin errors++; $display("FAIL mismatch_ok: got %b required 0", ok[0]); end
    checks++; if (err[0] !== 2'b01) begin errors++; $display("FAIL mismatch_err: got %b required 01", err[0]); end
    checks++; if (crc[0] !== 16'h2042) begin errors++; $display("FAIL mismatch_crc: got %h required 2042", crc[0]); end
  endtask

  task automatic test_default_init();
    xfer(1'b1, 1'b0, 16'hFFFF);
    xfer(1'b0, 1'b1, 16'h0000);
    checks++; if (v[1] !== 1'b1) begin errors++; $display("FAIL dflt_valid: got %b required 1", v[1]); end
    checks++; if (ok[1] !== 1'b1) begin errors++; $display("FAIL dflt_ok: got %b required 1", ok[1]); end
    checks++; if (crc[1] !== 16'h0000) begin errors++; $display("FAIL dflt_crc: got %h required 0000", crc[1]); end
    checks++; if (rdy[1] !== 1'b0) begin errors++; $display("FAIL dflt_report_ready: got %b required 0", rdy[1]); end
    tick();
    checks++; if (rdy[1] !== 1'b1) begin errors++; $display("FAIL dflt_ready_back: got %b required 1", rdy[1]); end
    checks++; if (crc[1] !== 16'h0000 || ok[1] !== 1'b1) begin errors++; $display("FAIL dflt_held: crc=%h ok=%b required 0000/1", crc[1], ok[1]); end
  endtask

  task automatic test_abort();
    xfer(1'b1, 1'b0, 16'h1234);
    xfer(1'b0, 1'b0, 16'h5678);
    xfer(1'b1, 1'b0, 16'hFFFF);
    checks++; if (v[1] !== 1'b1) begin errors++; $display("FAIL abort_valid: got %b required 1", v[1]); end
    checks++; if (err[1] !== 2'b11) begin errors++; $display("FAIL abort_err: got %b required 11", err[1]); end
    checks++; if (len[1] !== 16'd2) begin errors++; $display("FAIL abort_len: got %0d required 2", len[1]); end
    checks++; if (ok[1] !== 1'b0) begin errors++; $display("FAIL abort_ok: got %b required 0", ok[1]); end
    checks++; if (rdy[1] !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b required 1", rdy[1]); end
    xfer(1'b0, 1'b1, 16'h0000);
    checks++; if (v[1] !== 1'b1 || ok[1] !== 1'b1) begin errors++; $display("FAIL restart_ok: valid=%b ok=%b required 1/1", v[1], ok[1]); end
    checks++; if (len[1] !== 16'd1) begin errors++; $display("FAIL restart_len: got %0d required 1", len[1]); end
    xfer(1'b1, 1'b0, 16'h1111);
    xfer(1'b1, 1'b1, 16'h2222);
    checks++; if (v[1] !== 1'b1 || err[1] !== 2'b11) begin errors++; $display("FAIL abort_eof: valid=%b err=%b required 1/11", v[1], err[1]); end
    checks++; if (len[1] !== 16'd1) begin errors++; $display("FAIL abort_eof_len: got %0d required 1", len[1]); end
    checks++; if (rdy[1] !== 1'b0) begin errors++; $display("FAIL abort_eof_report: in_ready=%b required 0", rdy[1]); end
  endtask

  task automatic test_length();
    // INIT=0: 0x0001 -> 0x1021, 0x1021 -> 0x0000, 0x0000 -> 0x0000.
    xfer(1'b1, 1'b0, 16'h0001);
    xfer(1'b0, 1'b0, 16'h1021);
    xfer(1'b0, 1'b0, 16'h0000);
    xfer(1'b0, 1'b1, 16'h0000);
    checks++; if (v[2] !== 1'b1 || err[2] !== 2'b10) begin errors++; $display("FAIL len_err: valid=%b err=%b required 1/10", v[2], err[2]); end
    checks++; if (len[2] !== 16'd3 || ok[2] !== 1'b0) begin errors++; $display("FAIL len_count: len=%0d ok=%b required 3/0", len[2], ok[2]); end
    checks++; if (err[0] !== 2'b00 || ok[0] !== 1'b1) begin errors++; $display("FAIL len_within_max: err=%b ok=%b required 00/1", err[0], ok[0]); end
    xfer(1'b1, 1'b1, 16'h1234);
    checks++; if (v[2] !== 1'b1 || err[2] !== 2'b10) begin errors++; $display("FAIL sofeof_err: valid=%b err=%b required 1/10", v[2], err[2]); end
    checks++; if (len[2] !== 16'd0) begin errors++; $display("FAIL sofeof_len: got %0d required 0", len[2]); end
    checks++; if (crc[1] !== 16'hFFFF || crc[2] !== 16'h0000) begin errors++; $display("FAIL sofeof_crc: b=%h c=%h required ffff/0000", crc[1], crc[2]); end
  endtask

  task automatic test_reset_midframe();
    xfer(1'b1, 1'b0, 16'h1234);
    xfer(1'b0, 1'b0, 16'h5678);
    reset_n = 1'b0;
    tick();
    checks++; if (v !== 3'b000 || rdy !== 3'b000) begin errors++; $display("FAIL midreset_quiet: valid=%b ready=%b required 000/000", v, rdy); end
    tick();
    reset_n = 1'b1;
    tick();
    checks++; if (v !== 3'b000 || len[1] !== 16'd0) begin errors++; $display("FAIL midreset_no_report: valid=%b len=%0d required 000/0", v, len[1]); end
    xfer(1'b1, 1'b0, 16'hFFFF);
    xfer(1'b0, 1'b1, 16'h0000);
    checks++; if (v[1] !== 1'b1 || ok[1] !== 1'b1 || len[1] !== 16'd1) begin errors++; $display("FAIL midreset_new: valid=%b ok=%b len=%0d required 1/1/1", v[1], ok[1], len[1]); end
    xfer(1'b1, 1'b0, 16'hFFFF);
    xfer(1'b0, 1'b1, 16'h0001);
    checks++; if (v[1] !== 1'b1 || err[1] !== 2'b01) begin errors++; $display("FAIL midreset_bad: valid=%b err=%b required 1/01", v[1], err[1]); end
    repeat (2) tick();
`ifdef CRC16_CHK_STATS_EN
    checks++; if (good[1] !== 16'd1) begin errors++; $display("FAIL stats_good: got %0d required 1", good[1]); end
    checks++; if (bad[1] !== 16'd1) begin errors++; $display("FAIL stats_bad: got %0d required 1", bad[1]); end
`endif
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_data = 16'h0; in_sof = 1'b0; in_eof = 1'b0;
    test_reset();
    test_idle_ignore();
    test_match();
    test_mismatch();
    test_default_init();
    test_abort();
    test_length();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc16_frame_checker.md
CRC16_FRAME_CHECKER -- requirements
Module: crc16_frame_checker

Interface
REQ-001 SHALL have parameter CRC_INIT, default 16'hFFFF, initial CRC register value at each frame start.
REQ-002 SHALL have parameter MAX_WORDS, default 256, maximum data words per frame, excluding the CRC word.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  input word present.
REQ-006 SHALL have port in_ready  output  1  checker accepts the word; a word transfers when in_valid && in_ready.
REQ-007 SHALL have port in_data  input  16  data word, or the received CRC when in_eof=1.
REQ-008 SHALL have port in_sof  input  1  first data word of a frame.
REQ-009 SHALL have port in_eof  input  1  word is the trailing received CRC.
REQ-010 SHALL have port chk_valid  output  1  one-cycle result pulse.
REQ-011 SHALL have port chk_ok  output  1  frame passed; valid with chk_valid.
REQ-012 SHALL have port chk_err  output  2  00 none, 01 CRC mismatch, 10 length error, 11 aborted by new sof.
REQ-013 SHALL have port crc_calc  output  16  computed CRC of the last reported frame, held until the next report.
REQ-014 SHALL have port frame_len  output  16  data-word count of the last reported frame, held until the next report.

Function
REQ-015 SHALL use CRC-16 polynomial 0x1021, MSB-first, no reflection, no final XOR, and fold one 16-bit word per transfer: crc_next = ((crc ^ word) * x^16) mod G.
REQ-016 SHALL implement FSM states IDLE, DATA and REPORT.
REQ-017 SHALL, in IDLE, keep in_ready=1 and silently consume words without sof.
REQ-018 SHALL, in IDLE on an accepted word with sof=1 and eof=0, load crc = step(CRC_INIT, word), set count=1 and go to DATA.
REQ-019 SHALL, on an accepted word with sof=1 and eof=1, report chk_err=10, frame_len=0 and crc_calc=CRC_INIT, and go to REPORT.
REQ-020 SHALL, in DATA, keep in_ready=1 and, on an accepted word with sof=0 and eof=0, fold the word and increment count, saturating at 16'hFFFF.
REQ-021 SHALL, in DATA on an accepted word with eof=1, compare in_data to crc and go to REPORT.
REQ-022 SHALL, at eof with count > MAX_WORDS, report err=10; otherwise a mismatch reports err=01 and a match reports err=00 with chk_ok=1.
REQ-023 SHALL, in DATA on an accepted word with sof=1, report err=11 for the old frame and restart in DATA with this word as word 1 (CRC reinitialised, count=1) in the same cycle.
REQ-024 SHALL, in DATA on an accepted word with sof=1 and eof=1, report err=11 and go to REPORT.
REQ-025 SHALL register all reports: chk_valid pulses exactly 1 cycle after the eof or abort transfer, and crc_calc and frame_len update in that same cycle.
REQ-026 SHALL, in REPORT, hold in_ready=0 for exactly one cycle, then return to IDLE.
REQ-027 SHALL leave chk_ok and chk_err undefined-free when chk_valid=0, held at their last values.

Reset
REQ-028 SHALL, on clk edge with reset_n=0, enter IDLE and clear chk_valid, chk_ok, chk_err, frame_len and count to 0, set crc_calc=CRC_INIT and crc=CRC_INIT.
REQ-029 SHALL hold in_ready=0 while reset_n=0.
REQ-030 SHALL discard any partial frame on reset mid-frame with no report.

Configuration
REQ-031 SHALL, with CRC16_CHK_STATS_EN defined, add 16-bit outputs good_cnt and bad_cnt that increment on each chk_valid with chk_ok=1 and chk_ok=0 respectively, saturate at 16'hFFFF and reset to 0.
REQ-032 SHALL, without CRC16_CHK_STATS_EN, omit those ports and counters entirely.

Structure
REQ-033 SHALL place the constant CRC16_POLY=16'h1021, the FSM state enum and the chk_err code constants in package crc16_pkg, shared with crc16_parallel.
REQ-034 SHALL implement the word-fold as combinational sub-module crc16_step (crc_in[15:0], data_in[15:0] -> crc_out[15:0]), instantiated once.

Verification
REQ-035 SHALL verify with CRC_INIT=0: sof 0x0001, then eof 0x1021 -> chk_valid next cycle, chk_ok=1, err=00, crc_calc=0x1021, frame_len=1.
REQ-036 SHALL verify with CRC_INIT=0: sof 0x0002, then eof 0x1021 -> chk_ok=0, err=01, crc_calc=0x2042.
REQ-037 SHALL verify with default CRC_INIT: sof 0xFFFF, then eof 0x0000 -> chk_ok=1, crc_calc=0x0000; in_ready=0 for exactly the following cycle.
REQ-038 SHALL verify: sof 0x1234, 0x5678, then sof 0xFFFF, eof 0x0000 -> first report err=11 with frame_len=2, second report chk_ok=1 with frame_len=1.
REQ-039 SHALL verify with MAX_WORDS=2: a 3-word frame with correct CRC -> err=10, frame_len=3; separately, sof+eof on one word -> err=10, frame_len=0.
REQ-040 SHALL verify: reset_n=0 mid-frame after 2 words, then a new valid frame -> no report for the partial frame, correct report for the new one; with CRC16_CHK_STATS_EN, good_cnt and bad_cnt match the report tally.
